aes_input_packer: RTL and testbench

Host-side ingress stage directly upstream of `aes_controller`. Gathers four 32-bit host words plus command sideband into one `in_packet_t` (128-bit data, `en_de`, `set_key`) and holds completed packets in a 2-entry FIFO. Presents them to the controller under a valid/ready handshake. Decouples a narrow, stalling host bus from the controller's one-packet-per-cycle input.

---
 rtl/aes_input_packer.sv | 145 ++++++++++++++
 tb/tb_aes_input_packer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_input_packer.sv
// Host ingress packer: gathers four 32-bit words plus command sideband into one
// in_packet_t and queues it in a 2-entry FIFO. Define AES_PACKER_TIMEOUT_EN to discard stalled partial packets.

package aes_packer_pkg;
  typedef struct packed {
    logic         valid;
    logic [127:0] data;
    logic         en_de;
    logic         set_key;
  } in_packet_t;
endpackage

module aes_input_packer
  import aes_packer_pkg::*;
#(
  parameter int DEPTH          = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         word_valid,
  output logic         word_ready,
  input  logic [31:0]  word_data,
  input  logic         word_en_de,
  input  logic         word_set_key,
  input  logic         abort,
  output in_packet_t   pkt_out,
  input  logic         pkt_ready,
  output logic         busy,
  output logic         err_timeout
);

  if (DEPTH != 2) begin : g_depth_check
    $error("aes_input_packer supports DEPTH == 2 only");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
    $error("aes_input_packer needs TIMEOUT_CYCLES >= 1");
  end

  logic [1:0]   wcnt;
  logic [95:0]  asm_hi;
  logic         asm_en_de;
  logic         asm_set_key;

  logic [129:0] fifo_mem [2];
  logic [129:0] head;
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;

  logic         accept;
  logic         push;
  logic         pop;
  logic         clear_asm;
  logic         timeout_fire;

  // Ready depends only on registered state, so pkt_ready never reaches word_ready.
  assign word_ready = (wcnt != 2'd3) || (count != 2'd2);
  assign busy       = (wcnt != 2'd0);
  assign accept     = word_valid && word_ready;
  assign pop        = (count != 2'd0) && pkt_ready;
  assign clear_asm  = abort || timeout_fire;
  assign push       = accept && (wcnt == 2'd3) && !clear_asm;
  assign head       = fifo_mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt        <= 2'd0;
      asm_hi      <= '0;
      asm_en_de   <= 1'b0;
      asm_set_key <= 1'b0;
    end else if (clear_asm) begin
      wcnt        <= 2'd0;
      asm_hi      <= '0;
      asm_en_de   <= 1'b0;
      asm_set_key <= 1'b0;
    end else if (accept) begin
      wcnt <= wcnt + 2'd1;
      case (wcnt)
        2'd0: begin
          asm_hi[95:64] <= word_data;
          asm_en_de     <= word_en_de;
          asm_set_key   <= word_set_key;
        end
        2'd1:    asm_hi[63:32] <= word_data;
        2'd2:    asm_hi[31:0]  <= word_data;
        default: asm_hi        <= asm_hi;
      endcase
    end
  end

  // Word 3 bypasses the assembly register and lands in the FIFO on its own edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) fifo_mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= {asm_hi, word_data, asm_en_de, asm_set_key};
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    pkt_out         = '0;
    pkt_out.valid   = (count != 2'd0);
    pkt_out.data    = head[129:2];
    pkt_out.en_de   = head[1];
    pkt_out.set_key = head[0];
  end

`ifdef AES_PACKER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tcnt;

  // An accepted word on the expiry edge counts as activity and suppresses the timeout.
  assign timeout_fire = busy && !accept && !abort && (tcnt == TLAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt        <= '0;
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= timeout_fire;
      if (!busy || accept || abort || timeout_fire) tcnt <= '0;
      else                                          tcnt <= tcnt + TW'(1);
    end
  end
`else
  assign timeout_fire = 1'b0;
  assign err_timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_aes_input_packer.sv
// Scoreboard bench for aes_input_packer: stimulus queues expected packets,
// a negedge monitor pops and compares each packet the DUT hands over.

module tb_aes_input_packer;
  import aes_packer_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        word_valid;
  logic        word_ready;
  logic [31:0] word_data;
  logic        word_en_de;
  logic        word_set_key;
  logic        abort;
  in_packet_t  pkt_out;
  logic        pkt_ready;
  logic        busy;
  logic        err_timeout;

  typedef struct {
    logic [127:0] data;
    logic         en_de;
    logic         set_key;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   pops   = 0;
  int   pulses;

  aes_input_packer #(.DEPTH(2), .TIMEOUT_CYCLES(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .word_data    (word_data),
    .word_en_de   (word_en_de),
    .word_set_key (word_set_key),
    .abort        (abort),
    .pkt_out      (pkt_out),
    .pkt_ready    (pkt_ready),
    .busy         (busy),
    .err_timeout  (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s: actual %h required %h", name, actual, required);
    end
  endtask

  task automatic checkFlag(input string name, input logic actual, input logic required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s: actual %b required %b", name, actual, required);
    end
  endtask

  task automatic expectPacket(input logic [127:0] d, input logic en, input logic sk);
    exp_t e;
    e.data    = d;
    e.en_de   = en;
    e.set_key = sk;
    exp_q.push_back(e);
  endtask

  // Offers one word and waits (bounded) for the edge that accepts it.
  task automatic applyStimulus(input logic [31:0] d, input logic en, input logic sk);
    int   waited = 0;
    logic acc    = 1'b0;
    word_valid   = 1'b1;
    word_data    = d;
    word_en_de   = en;
    word_set_key = sk;
    while (!acc && waited < 50) begin
      @(negedge clk);
      acc = word_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    checkFlag("word_accept", acc, 1'b1);
    word_valid = 1'b0;
  endtask

  task automatic sendPacket(input logic [127:0] d, input logic en, input logic sk);
    for (int i = 0; i < 4; i++) applyStimulus(d[127-32*i -: 32], en, sk);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && pkt_out.valid && pkt_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL pkt_unexpected: actual data %h required no packet", pkt_out.data);
      end else begin
        e = exp_q.pop_front();
        pops++;
        checkOutput("pkt_data", pkt_out.data, e.data);
        checkFlag("pkt_en_de", pkt_out.en_de, e.en_de);
        checkFlag("pkt_set_key", pkt_out.set_key, e.set_key);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: actual still running required finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    rst          = 1'b1;
    word_valid   = 1'b0;
    word_data    = '0;
    word_en_de   = 1'b0;
    word_set_key = 1'b0;
    abort        = 1'b0;
    pkt_ready    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkFlag("rst_word_ready", word_ready, 1'b1);
    checkFlag("rst_valid", pkt_out.valid, 1'b0);
    checkOutput("rst_data", pkt_out.data, 128'h0);
    checkFlag("rst_en_de", pkt_out.en_de, 1'b0);
    checkFlag("rst_set_key", pkt_out.set_key, 1'b0);
    checkFlag("rst_busy", busy, 1'b0);
    checkFlag("rst_err_timeout", err_timeout, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single packet, consumer always ready
    pkt_ready = 1'b1;
    expectPacket(128'hDEADBEEF_CAFE1234_5678ABCD_01234567, 1'b1, 1'b0);
    applyStimulus(32'hDEADBEEF, 1'b1, 1'b0);
    applyStimulus(32'hCAFE1234, 1'b0, 1'b0);
    applyStimulus(32'h5678ABCD, 1'b0, 1'b0);
    applyStimulus(32'h01234567, 1'b0, 1'b0);
    checkFlag("single_valid", pkt_out.valid, 1'b1);
    @(posedge clk);
    #1;
    checkFlag("single_valid_drop", pkt_out.valid, 1'b0);

    // Backpressure: two queued packets, third stalls on its last word
    pkt_ready = 1'b0;
    expectPacket(128'h01234567_89ABCDEF_FEDCBA98_76543210, 1'b0, 1'b1);
    expectPacket(128'h11111111_22222222_33333333_44444444, 1'b1, 1'b0);
    expectPacket(128'hAAAA0000_BBBB1111_CCCC2222_DDDD3333, 1'b0, 1'b0);
    sendPacket(128'h01234567_89ABCDEF_FEDCBA98_76543210, 1'b0, 1'b1);
    sendPacket(128'h11111111_22222222_33333333_44444444, 1'b1, 1'b0);
    applyStimulus(32'hAAAA0000, 1'b0, 1'b0);
    applyStimulus(32'hBBBB1111, 1'b0, 1'b0);
    applyStimulus(32'hCCCC2222, 1'b0, 1'b0);
    checkOutput("bp_head_data", pkt_out.data, 128'h01234567_89ABCDEF_FEDCBA98_76543210);
    word_valid = 1'b1;
    word_data  = 32'hDDDD3333;
    repeat (3) begin
      @(negedge clk);
      checkFlag("bp_stall_ready", word_ready, 1'b0);
    end
    @(posedge clk);
    #1;
    checkOutput("bp_head_hold", pkt_out.data, 128'h01234567_89ABCDEF_FEDCBA98_76543210);
    checkFlag("bp_busy_stalled", busy, 1'b1);
    pkt_ready = 1'b1;
    @(posedge clk);
    #1;
    pkt_ready = 1'b0;
    checkFlag("bp_ready_after_pop", word_ready, 1'b1);
    checkFlag("bp_busy_before_last", busy, 1'b1);
    @(posedge clk);
    #1;
    word_valid = 1'b0;
    checkFlag("bp_b_complete", busy, 1'b0);
    checkFlag("bp_fifo_full_again", word_ready, 1'b1);
    pkt_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkFlag("bp_drained", pkt_out.valid, 1'b0);

    // Sideband sampled on word 0 only
    expectPacket(128'h0F0F0F0F_F0F0F0F0_12121212_34343434, 1'b0, 1'b1);
    applyStimulus(32'h0F0F0F0F, 1'b0, 1'b1);
    applyStimulus(32'hF0F0F0F0, 1'b1, 1'b0);
    applyStimulus(32'h12121212, 1'b0, 1'b0);
    applyStimulus(32'h34343434, 1'b1, 1'b0);
    @(posedge clk);
    #1;

    // Abort after two words, then a fresh packet
    applyStimulus(32'h99999999, 1'b1, 1'b1);
    applyStimulus(32'h88888888, 1'b1, 1'b1);
    checkFlag("abort_busy_before", busy, 1'b1);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    checkFlag("abort_busy_after", busy, 1'b0);
    expectPacket(128'h13579BDF_2468ACE0_FEEDFACE_C0FFEE00, 1'b1, 1'b0);
    sendPacket(128'h13579BDF_2468ACE0_FEEDFACE_C0FFEE00, 1'b1, 1'b0);
    @(posedge clk);
    #1;

    // Abort coinciding with word 3: nothing pushed, counter back at 0
    applyStimulus(32'h77777777, 1'b0, 1'b1);
    applyStimulus(32'h66666666, 1'b0, 1'b1);
    applyStimulus(32'h55555555, 1'b0, 1'b1);
    word_valid = 1'b1;
    word_data  = 32'h44444444;
    abort      = 1'b1;
    @(posedge clk);
    #1;
    word_valid = 1'b0;
    abort      = 1'b0;
    checkFlag("abort3_busy", busy, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checkFlag("abort3_no_push", pkt_out.valid, 1'b0);
    expectPacket(128'h00000001_00000002_00000003_00000004, 1'b1, 1'b1);
    sendPacket(128'h00000001_00000002_00000003_00000004, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    #1;

    // Partial packet left idle
    applyStimulus(32'hAAAAAAAA, 1'b0, 1'b0);
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (err_timeout) pulses++;
    end
    @(posedge clk);
    #1;
`ifdef AES_PACKER_TIMEOUT_EN
    checkOutput("timeout_pulses", 128'(pulses), 128'd1);
    checkFlag("timeout_busy", busy, 1'b0);
`else
    checkOutput("timeout_pulses", 128'(pulses), 128'd0);
    checkFlag("timeout_busy", busy, 1'b1);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
`endif
    checkFlag("timeout_no_push", pkt_out.valid, 1'b0);

    // Async reset with the FIFO full and a partial packet stalled
    pkt_ready = 1'b0;
    sendPacket(128'h5A5A5A5A_A5A5A5A5_3C3C3C3C_C3C3C3C3, 1'b1, 1'b1);
    sendPacket(128'h69696969_96969696_0F0F0F0F_F0F0F0F0, 1'b0, 1'b1);
    applyStimulus(32'h10101010, 1'b1, 1'b0);
    applyStimulus(32'h20202020, 1'b1, 1'b0);
    applyStimulus(32'h30303030, 1'b1, 1'b0);
    checkFlag("full_valid", pkt_out.valid, 1'b1);
    checkFlag("full_word_ready", word_ready, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checkFlag("arst_valid", pkt_out.valid, 1'b0);
    checkOutput("arst_data", pkt_out.data, 128'h0);
    checkFlag("arst_word_ready", word_ready, 1'b1);
    checkFlag("arst_busy", busy, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    checkOutput("queue_empty", 128'(exp_q.size()), 128'd0);
    checkOutput("pop_count", 128'(pops), 128'd7);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
